// File: rtl/score_seg_display.sv
// Binary score to multiplexed 7-segment display: iterative double-dabble
// conversion into an atomically updated display register, plus a refresh scanner.
module score_seg_display #(
    parameter int BIN_W          = 14,
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  value,
    input  logic              load,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);
    localparam int BW = 4 * (DIGITS + 1);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(BIN_W - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [VW-1:0] LAST_DIV = VW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [BIN_W-1:0] bin;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_adj;
    logic [CW-1:0]   cnt;
    logic            sticky;
    logic [DW-1:0]   disp;

    genvar g;
    generate
        for (g = 0; g < DIGITS + 1; g++) begin : g_adj
            assign bcd_adj[4*g +: 4] = (bcd[4*g +: 4] >= 4'd5) ? bcd[4*g +: 4] + 4'd3
                                                                : bcd[4*g +: 4];
        end
    endgenerate

    // sticky catches bits pushed out of the top nibble for very wide inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
            disp     <= '0;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin    <= value;
                        bcd    <= '0;
                        cnt    <= '0;
                        sticky <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd    <= {bcd_adj[BW-2:0], bin[BIN_W-1]};
                    bin    <= bin << 1;
                    sticky <= sticky | bcd_adj[BW-1];
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (sticky || bcd[BW-1 -: 4] != 4'd0) begin
                        disp     <= {DIGITS{4'h9}};
                        overflow <= 1'b1;
                    end else begin
                        disp     <= bcd[DW-1:0];
                        overflow <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 7'h3F;
            4'd1: glyph = 7'h06;
            4'd2: glyph = 7'h5B;
            4'd3: glyph = 7'h4F;
            4'd4: glyph = 7'h66;
            4'd5: glyph = 7'h6D;
            4'd6: glyph = 7'h7D;
            4'd7: glyph = 7'h07;
            4'd8: glyph = 7'h7F;
            4'd9: glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    logic [VW-1:0]     div;
    logic [IW-1:0]     idx;
    logic [DW-1:0]     upper;
    logic              blank;
    logic              dp;
    logic [7:0]        seg_ah;
    logic [DIGITS-1:0] an_ah;

    // upper holds the current digit and everything above it, for blanking
    always_comb begin
        upper  = disp >> {idx, 2'b00};
        blank  = blank_lz && (idx != '0) && (upper == '0);
        an_ah  = DIGITS'(1) << idx;
        dp     = |(dp_mask & an_ah);
        seg_ah = {dp, blank ? 7'h00 : glyph(upper[3:0])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
            an  <= SEG_ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);
            seg <= SEG_ACTIVE_LOW ? 8'hC0 : 8'h3F;
        end else begin
            if (div == LAST_DIV) begin
                div <= '0;
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
            an  <= SEG_ACTIVE_LOW ? ~an_ah : an_ah;
            seg <= SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
        end
    end
endmodule

// File: tb/tb_score_seg_display.sv
// Bench for score_seg_display: two configurations checked every cycle against
// a decimal-arithmetic model, plus hand-computed scan/overflow/blanking vectors.
module tb_score_seg_display;
    localparam int BA = 14, DA = 4, RA = 4;
    localparam int BB = 20, DB = 6, RB = 3;

    logic clk, rst, blank_lz;
    logic [BA-1:0] value_a;
    logic          load_a;
    logic [DA-1:0] dp_a;
    logic          busy_a, ovf_a;
    logic [7:0]    seg_a;
    logic [DA-1:0] an_a;
    logic [BB-1:0] value_b;
    logic          load_b;
    logic [DB-1:0] dp_b;
    logic          busy_b, ovf_b;
    logic [7:0]    seg_b;
    logic [DB-1:0] an_b;

    int n_cmp = 0;
    int n_bad = 0;

    score_seg_display #(.BIN_W(BA), .DIGITS(DA), .REFRESH_DIV(RA), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .value(value_a), .load(load_a), .blank_lz(blank_lz),
        .dp_mask(dp_a), .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a));

    score_seg_display #(.BIN_W(BB), .DIGITS(DB), .REFRESH_DIV(RB), .SEG_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .value(value_b), .load(load_b), .blank_lz(blank_lz),
        .dp_mask(dp_b), .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .an(an_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
            8: return 7'h7F; default: return 7'h6F;
        endcase
    endfunction

    // Expected registered outputs when digit idx of decimal value disp is shown
    function automatic void exp_out(input longint disp, input int idx, input logic blz,
                                    input logic [7:0] dpm, input bit al,
                                    output logic [7:0] s, output logic [7:0] a);
        longint q;
        q = disp / pow10(idx);
        s[7] = dpm[idx];
        s[6:0] = (blz && idx > 0 && q == 0) ? 7'h00 : glyph(int'(q % 10));
        a = 8'd1 << idx;
        if (al) begin
            s = ~s;
            a = ~a;
        end
    endfunction

    function automatic void conv(input longint v, input int nd, output longint r, output bit ov);
        ov = (v >= pow10(nd));
        r  = ov ? pow10(nd) - 1 : v;
    endfunction

    // Model A: ka = edges since reset; done edge = load edge + BIN_W + 1
    longint da, pend_a;
    int     ka, dka;
    bit     acta, pov_a, m_ovfa, m_busya;
    logic [7:0] m_sega, m_ana;
    always @(posedge clk) begin : model_a
        logic [7:0] s, a;
        longint r;
        bit ov;
        if (rst) begin
            exp_out(0, 0, 1'b0, 8'h00, 1'b1, s, a);
            ka <= 0; da <= 0; m_ovfa <= 0; acta <= 0; m_busya <= 0;
            m_sega <= s; m_ana <= a;
        end else begin
            exp_out(da, (ka / RA) % DA, blank_lz, {4'h0, dp_a}, 1'b1, s, a);
            m_sega <= s; m_ana <= a;
            ka <= ka + 1;
            if (acta && ka + 1 == dka) begin
                da <= pend_a; m_ovfa <= pov_a; acta <= 0; m_busya <= 0;
            end else if (!acta && load_a) begin
                conv(longint'(value_a), DA, r, ov);
                acta <= 1; dka <= ka + 1 + BA + 1; pend_a <= r; pov_a <= ov; m_busya <= 1;
            end
        end
    end

    longint db, pend_b;
    int     kb, dkb;
    bit     actb, pov_b, m_ovfb, m_busyb;
    logic [7:0] m_segb, m_anb;
    always @(posedge clk) begin : model_b
        logic [7:0] s, a;
        longint r;
        bit ov;
        if (rst) begin
            exp_out(0, 0, 1'b0, 8'h00, 1'b0, s, a);
            kb <= 0; db <= 0; m_ovfb <= 0; actb <= 0; m_busyb <= 0;
            m_segb <= s; m_anb <= a;
        end else begin
            exp_out(db, (kb / RB) % DB, blank_lz, {2'b00, dp_b}, 1'b0, s, a);
            m_segb <= s; m_anb <= a;
            kb <= kb + 1;
            if (actb && kb + 1 == dkb) begin
                db <= pend_b; m_ovfb <= pov_b; actb <= 0; m_busyb <= 0;
            end else if (!actb && load_b) begin
                conv(longint'(value_b), DB, r, ov);
                actb <= 1; dkb <= kb + 1 + BB + 1; pend_b <= r; pov_b <= ov; m_busyb <= 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Advance one cycle and compare every output against the model
    task automatic tick();
        @(negedge clk);
        chk("a_an",   32'(an_a),   32'(m_ana[DA-1:0]));
        chk("a_seg",  32'(seg_a),  32'(m_sega));
        chk("a_busy", 32'(busy_a), 32'(m_busya));
        chk("a_ovf",  32'(ovf_a),  32'(m_ovfa));
        chk("b_an",   32'(an_b),   32'(m_anb[DB-1:0]));
        chk("b_seg",  32'(seg_b),  32'(m_segb));
        chk("b_busy", 32'(busy_b), 32'(m_busyb));
        chk("b_ovf",  32'(ovf_b),  32'(m_ovfb));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy_a === 1'b1 || busy_b === 1'b1) && t < 80) begin
            tick();
            t++;
        end
        chk("busy_timeout", 32'(busy_a | busy_b), 32'd0);
    endtask

    task automatic load_val_a(input int v);
        value_a = BA'(v);
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
    endtask

    // segs[8*j +: 8] = expected seg while digit j is active
    task automatic scan_a(input logic [31:0] segs);
        for (int j = 0; j < DA; j++) begin
            logic [DA-1:0] want;
            int t = 0;
            want = ~(DA'(1) << j);
            while (an_a !== want && t < 4 * RA * DA) begin
                tick();
                t++;
            end
            chk($sformatf("a_an_reach%0d", j), 32'(an_a), 32'(want));
            chk($sformatf("a_seg_dig%0d", j), 32'(seg_a), 32'(segs[8*j +: 8]));
        end
    endtask

    task automatic scan_b(input logic [47:0] segs);
        for (int j = 0; j < DB; j++) begin
            logic [DB-1:0] want;
            int t = 0;
            want = DB'(1) << j;
            while (an_b !== want && t < 4 * RB * DB) begin
                tick();
                t++;
            end
            chk($sformatf("b_an_reach%0d", j), 32'(an_b), 32'(want));
            chk($sformatf("b_seg_dig%0d", j), 32'(seg_b), 32'(segs[8*j +: 8]));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; load_a = 1'b0; value_a = '0; blank_lz = 1'b0; dp_a = '0;
        load_b = 1'b0; value_b = '0; dp_b = '0;
        ticks(3);
        chk("rst_an",   32'(an_a),   32'h0E);
        chk("rst_seg",  32'(seg_a),  32'hC0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ovf",  32'(ovf_a),  32'd0);
        chk("rst_b_seg", 32'(seg_b), 32'h3F);
        rst = 1'b0;
        ticks(2);

        // 1234: busy spans SHIFT + DONE
        load_val_a(1234);
        n = 0;
        while (busy_a === 1'b1 && n < 60) begin
            n++;
            tick();
        end
        chk("busy_len_1234", 32'(n), 32'd15);
        ticks(2);
        scan_a({8'hF9, 8'hA4, 8'hB0, 8'h99});

        load_val_a(9999); wait_idle(); ticks(2);
        chk("ovf_9999", 32'(ovf_a), 32'd0);
        scan_a({4{8'h90}});
        load_val_a(12000); wait_idle(); ticks(2);
        chk("ovf_12000", 32'(ovf_a), 32'd1);
        scan_a({4{8'h90}});

        // leading-zero blanking and live decimal points
        blank_lz = 1'b1;
        load_val_a(7); wait_idle(); ticks(2);
        chk("ovf_7", 32'(ovf_a), 32'd0);
        scan_a({8'hFF, 8'hFF, 8'hFF, 8'hF8});
        dp_a = 4'b0100;
        ticks(1);
        scan_a({8'hFF, 8'h7F, 8'hFF, 8'hF8});
        blank_lz = 1'b0; dp_a = '0;

        // second load during conversion is dropped
        load_val_a(1111);
        ticks(4);
        load_val_a(2222);
        wait_idle(); ticks(2);
        scan_a({4{8'hF9}});

        // load held high restarts right after DONE
        value_a = BA'(42); load_a = 1'b1;
        tick(); wait_idle();
        chk("hold_gap_low", 32'(busy_a), 32'd0);
        tick();
        chk("hold_restart", 32'(busy_a), 32'd1);
        load_a = 1'b0;
        wait_idle(); ticks(2);

        // reset mid-SHIFT discards the conversion
        load_val_a(4321);
        ticks(5);
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        ticks(2);
        scan_a({4{8'hC0}});
        ticks(25);
        scan_a({4{8'hC0}});

        // wide active-high instance
        value_b = BB'(654321); load_b = 1'b1;
        tick();
        load_b = 1'b0;
        wait_idle(); ticks(2);
        chk("b_ovf_654321", 32'(ovf_b), 32'd0);
        scan_b({8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06});
        ticks(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
